// File: rtl/ai_cache_arbiter.sv
// ai_cache_arbiter: round-robin arbiter/sequencer sharing one single-port cache
// among NUM_REQ requesters. Each access walks IDLE (grant) -> ISSUE (one-cycle
// cache enable) -> CAPTURE (register read data/hit) -> RESP (hold until the
// owner takes the response).
// Optional build macro AI_CACHE_ARB_STATS_EN adds saturating read statistics
// (stat_accesses / stat_hits / stat_misses).
module ai_cache_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int NUM_REQ    = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_hit,
  output logic                          rsp_we,
  output logic                          cache_read_en,
  output logic                          cache_write_en,
  output logic [ADDR_WIDTH-1:0]         cache_addr,
  output logic [DATA_WIDTH-1:0]         cache_wdata,
  input  logic [DATA_WIDTH-1:0]         cache_rdata,
  input  logic                          cache_hit,
  output logic                          busy
`ifdef AI_CACHE_ARB_STATS_EN
  ,
  output logic [31:0]                   stat_accesses,
  output logic [31:0]                   stat_hits,
  output logic [31:0]                   stat_misses
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   cache_addr_q, cache_addr_d;
  logic [DATA_WIDTH-1:0]   cache_wdata_q, cache_wdata_d;
  logic                    cache_read_en_q, cache_read_en_d;
  logic                    cache_write_en_q, cache_write_en_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                    rsp_hit_q, rsp_hit_d;
  logic                    rsp_we_q, rsp_we_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic                    busy_q, busy_d;

  logic                    grant_found_s;
  logic [IDX_W-1:0]        grant_idx_s;
  logic [IDX_W-1:0]        cand_s;
  logic [ADDR_WIDTH-1:0]   sel_addr_s;
  logic [DATA_WIDTH-1:0]   sel_wdata_s;

  // Rotating-priority search: first valid requester at or above the pointer, wrapping.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!grant_found_s && req_valid[cand_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Mux the winner's address/data slices out of the flattened request buses.
  always_comb begin
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_addr_s  = sel_addr_s  | (req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] &
                                   {ADDR_WIDTH{grant_idx_s == IDX_W'(i)}});
      sel_wdata_s = sel_wdata_s | (req_wdata[i*DATA_WIDTH +: DATA_WIDTH] &
                                   {DATA_WIDTH{grant_idx_s == IDX_W'(i)}});
    end
  end

  // The accept pulse is combinational in IDLE and forced low while reset is held.
  assign req_ready = ((state_q == ST_IDLE) && reset && grant_found_s) ?
                     (ONE_HOT0 << grant_idx_s) : '0;

  // Sequencer next-state and next-output computation.
  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    owner_d          = owner_q;
    we_d             = we_q;
    cache_addr_d     = cache_addr_q;
    cache_wdata_d    = cache_wdata_q;
    cache_read_en_d  = 1'b0;
    cache_write_en_d = 1'b0;
    rsp_data_d       = rsp_data_q;
    rsp_hit_d        = rsp_hit_q;
    rsp_we_d         = rsp_we_q;
    rsp_valid_d      = rsp_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_found_s) begin
          owner_d          = grant_idx_s;
          we_d             = req_we[grant_idx_s];
          cache_addr_d     = sel_addr_s;
          cache_wdata_d    = sel_wdata_s;
          // Enables are loaded here so they are high for exactly the ISSUE cycle.
          cache_read_en_d  = !req_we[grant_idx_s];
          cache_write_en_d = req_we[grant_idx_s];
          ptr_d            = (int'(grant_idx_s) == NUM_REQ - 1) ? '0 : grant_idx_s + IDX_W'(1);
          state_d          = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // Cache read data and hit are valid in this cycle.
        rsp_data_d  = we_q ? '0 : cache_rdata;
        rsp_hit_d   = cache_hit;
        rsp_we_d    = we_q;
        rsp_valid_d = ONE_HOT0 << owner_q;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready[owner_q]) begin
          rsp_valid_d = '0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        rsp_valid_d = '0;
        state_d     = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Sequencer state and registered outputs; reset drops any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      ptr_q            <= '0;
      owner_q          <= '0;
      we_q             <= 1'b0;
      cache_addr_q     <= '0;
      cache_wdata_q    <= '0;
      cache_read_en_q  <= 1'b0;
      cache_write_en_q <= 1'b0;
      rsp_data_q       <= '0;
      rsp_hit_q        <= 1'b0;
      rsp_we_q         <= 1'b0;
      rsp_valid_q      <= '0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      ptr_q            <= ptr_d;
      owner_q          <= owner_d;
      we_q             <= we_d;
      cache_addr_q     <= cache_addr_d;
      cache_wdata_q    <= cache_wdata_d;
      cache_read_en_q  <= cache_read_en_d;
      cache_write_en_q <= cache_write_en_d;
      rsp_data_q       <= rsp_data_d;
      rsp_hit_q        <= rsp_hit_d;
      rsp_we_q         <= rsp_we_d;
      rsp_valid_q      <= rsp_valid_d;
      busy_q           <= busy_d;
    end
  end

  assign cache_read_en  = cache_read_en_q;
  assign cache_write_en = cache_write_en_q;
  assign cache_addr     = cache_addr_q;
  assign cache_wdata    = cache_wdata_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_hit        = rsp_hit_q;
  assign rsp_we         = rsp_we_q;
  assign busy           = busy_q;

`ifdef AI_CACHE_ARB_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 32'd1;
    end
  endfunction

  logic [31:0] stat_accesses_q, stat_accesses_d;
  logic [31:0] stat_hits_q, stat_hits_d;
  logic [31:0] stat_misses_q, stat_misses_d;

  // Read statistics: one access per read in CAPTURE, split into hit or miss.
  always_comb begin
    stat_accesses_d = stat_accesses_q;
    stat_hits_d     = stat_hits_q;
    stat_misses_d   = stat_misses_q;
    if ((state_q == ST_CAPTURE) && !we_q) begin
      stat_accesses_d = sat_inc(stat_accesses_q);
      if (cache_hit) begin
        stat_hits_d = sat_inc(stat_hits_q);
      end else begin
        stat_misses_d = sat_inc(stat_misses_q);
      end
    end else begin
      stat_accesses_d = stat_accesses_q;
    end
  end

  // Statistics counters, cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_accesses_q <= 32'd0;
      stat_hits_q     <= 32'd0;
      stat_misses_q   <= 32'd0;
    end else begin
      stat_accesses_q <= stat_accesses_d;
      stat_hits_q     <= stat_hits_d;
      stat_misses_q   <= stat_misses_d;
    end
  end

  assign stat_accesses = stat_accesses_q;
  assign stat_hits     = stat_hits_q;
  assign stat_misses   = stat_misses_q;
`endif

endmodule

// File: tb/tb_ai_cache_arbiter.sv
// Self-checking bench for ai_cache_arbiter (NUM_REQ=3) with a behavioural cache
// and a reference model of rotating priority and memory contents.
module tb_ai_cache_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid, rsp_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_data, cache_wdata, cache_rdata;
  logic            rsp_hit, rsp_we, cache_read_en, cache_write_en, cache_hit, busy;
  logic [AW-1:0]   cache_addr;
`ifdef AI_CACHE_ARB_STATS_EN
  logic [31:0]     stat_accesses, stat_hits, stat_misses;
`endif

  int total = 0;
  int bad   = 0;
  int exp_ptr = 0;
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] cmem [0:2047];
  logic          cval [0:2047];

  ai_cache_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(N)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_hit(rsp_hit), .rsp_we(rsp_we),
    .cache_read_en(cache_read_en), .cache_write_en(cache_write_en),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata),
    .cache_rdata(cache_rdata), .cache_hit(cache_hit), .busy(busy)
`ifdef AI_CACHE_ARB_STATS_EN
    , .stat_accesses(stat_accesses), .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural single-port cache: read data/hit valid the cycle after read_en, junk otherwise.
  always @(posedge clk) begin
    if (cache_write_en) begin
      cmem[cache_addr[10:0]] <= cache_wdata;
      cval[cache_addr[10:0]] <= 1'b1;
    end
    if (cache_read_en && cval[cache_addr[10:0]]) begin
      cache_rdata <= cmem[cache_addr[10:0]];
      cache_hit   <= 1'b1;
    end else begin
      cache_rdata <= {$urandom, $urandom};
      cache_hit   <= cache_read_en ? 1'b0 : 1'($urandom);
    end
  end

  function automatic logic [N-1:0] oh(input int i);
    oh = '0;
    oh[i] = 1'b1;
  endfunction

  // Reference arbitration: first valid index at or after the pointer, modulo N.
  function automatic int model_winner(input logic [N-1:0] v, input int p);
    model_winner = -1;
    for (int k = 0; k < N; k++)
      if (model_winner < 0 && v[(p + k) % N]) model_winner = (p + k) % N;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int r, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[r] = we;
    req_addr[r*AW +: AW] = a;
    req_wdata[r*DW +: DW] = d;
    req_valid[r] = 1'b1;
  endtask

  // Waits for any accept pulse, then drops the winner's valid in the following cycle.
  task automatic wait_grant(output logic [N-1:0] g, output bit tmo);
    tmo = 1'b1;
    g = '0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (req_ready !== '0) begin
        g = req_ready;
        tmo = 1'b0;
        break;
      end
      tick();
    end
    if (!tmo) begin
      tick();
      req_valid = req_valid & ~g;
    end
  endtask

  // Counts cycles from acceptance to rsp_valid and the cache enable pulses on the way.
  task automatic wait_rsp(input int w, output int lat, output int n_rd, output int n_wr,
                          output int n_both, output bit tmo);
    lat = 0; n_rd = 0; n_wr = 0; n_both = 0; tmo = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      lat++;
      if (cache_read_en === 1'b1) n_rd++;
      if (cache_write_en === 1'b1) n_wr++;
      if (cache_read_en === 1'b1 && cache_write_en === 1'b1) n_both++;
      if (rsp_valid[w] === 1'b1) begin
        tmo = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic release_rsp(input int w);
    rsp_ready[w] = 1'b1;
    tick();
    rsp_ready[w] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid = '1; req_we = '0; req_addr = '0; req_wdata = '0; rsp_ready = '1;
    tick(); tick();
    #1;
    total++;
    if ({req_ready, rsp_valid, cache_read_en, cache_write_en, rsp_hit, rsp_we, busy} !== '0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=0", {req_ready, rsp_valid, cache_read_en, cache_write_en, rsp_hit, rsp_we, busy});
    end
    total++;
    if ({cache_addr, cache_wdata, rsp_data} !== '0) begin
      bad++;
      $display("FAIL reset_bus got=%h want=0", {cache_addr, cache_wdata, rsp_data});
    end
`ifdef AI_CACHE_ARB_STATS_EN
    total++;
    if ({stat_accesses, stat_hits, stat_misses} !== '0) begin
      bad++;
      $display("FAIL reset_stats got=%h want=0", {stat_accesses, stat_hits, stat_misses});
    end
`endif
    tick();
    req_valid = '0; rsp_ready = '0; reset = 1'b1;
    exp_ptr = 0;
  endtask

  // One transaction with only requester r valid; checks grant, latency, enables and response.
  task automatic single_txn(input string nm, input int r, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
    logic [N-1:0] g;
    bit tmo;
    int lat, n_rd, n_wr, n_both, w;
    bit exp_hit;
    set_req(r, we, a, d);
    w = model_winner(oh(r), exp_ptr);
    exp_ptr = (w + 1) % N;
    wait_grant(g, tmo);
    total++;
    if (tmo || g !== oh(w)) begin bad++; $display("FAIL %s_grant got=%b want=%b", nm, g, oh(w)); end
    wait_rsp(w, lat, n_rd, n_wr, n_both, tmo);
    total++;
    if (tmo || lat != 3) begin bad++; $display("FAIL %s_latency got=%0d want=3", nm, lat); end
    total++;
    if (n_rd != (we ? 0 : 1) || n_wr != (we ? 1 : 0) || n_both != 0) begin
      bad++;
      $display("FAIL %s_enables got rd=%0d wr=%0d both=%0d want rd=%0d wr=%0d", nm, n_rd, n_wr, n_both, !we, we);
    end
    exp_hit = we ? 1'b0 : ref_mem.exists(a);
    total++;
    if (rsp_valid !== oh(w) || rsp_we !== we || busy !== 1'b1) begin
      bad++;
      $display("FAIL %s_rsp_ctrl got v=%b we=%b busy=%b want v=%b we=%b busy=1", nm, rsp_valid, rsp_we, busy, oh(w), we);
    end
    if (!we) begin
      total++;
      if (rsp_hit !== exp_hit || (exp_hit && rsp_data !== ref_mem[a])) begin
        bad++;
        $display("FAIL %s_read got hit=%b data=%h want hit=%b", nm, rsp_hit, rsp_data, exp_hit);
      end
    end else begin
      total++;
      if (rsp_data !== '0) begin bad++; $display("FAIL %s_wdata_zero got=%h want=0", nm, rsp_data); end
      ref_mem[a] = d;
    end
    release_rsp(w);
    #1;
    total++;
    if (rsp_valid !== '0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_release got v=%b busy=%b want 0/0", nm, rsp_valid, busy);
    end
  endtask

  task automatic test_write_read();
    single_txn("wr5", 0, 1'b1, 32'd5, 64'd50);
    single_txn("rd5", 0, 1'b0, 32'd5, 64'd0);
    total++;
    if (rsp_data !== 64'd50 || rsp_hit !== 1'b1) begin
      bad++;
      $display("FAIL rd5_value got data=%0d hit=%b want 50/1", rsp_data, rsp_hit);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] g;
    bit tmo;
    int lat, n_rd, n_wr, n_both, w, prev;
    prev = -1;
    set_req(0, 1'b0, 32'd10, 64'd0);
    set_req(1, 1'b0, 32'd20, 64'd0);
    for (int t = 0; t < 4; t++) begin
      w = model_winner(3'b011, exp_ptr);
      exp_ptr = (w + 1) % N;
      wait_grant(g, tmo);
      req_valid[1:0] = 2'b11;
      total++;
      if (tmo || g !== oh(w) || g === (prev >= 0 ? oh(prev) : '0)) begin
        bad++;
        $display("FAIL rr_grant%0d got=%b want=%b", t, g, oh(w));
      end
      prev = w;
      wait_rsp(w, lat, n_rd, n_wr, n_both, tmo);
      total++;
      if (tmo || rsp_hit !== 1'b0 || rsp_valid !== oh(w)) begin
        bad++;
        $display("FAIL rr_rsp%0d got v=%b hit=%b want v=%b hit=0", t, rsp_valid, rsp_hit, oh(w));
      end
      release_rsp(w);
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [N-1:0] g;
    bit tmo;
    int lat, n_rd, n_wr, n_both, w;
    set_req(0, 1'b0, 32'd5, 64'd0);
    w = model_winner(oh(0), exp_ptr);
    exp_ptr = (w + 1) % N;
    wait_grant(g, tmo);
    wait_rsp(0, lat, n_rd, n_wr, n_both, tmo);
    set_req(2, 1'b0, 32'd5, 64'd0);
    rsp_ready[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (tmo || rsp_valid !== oh(0) || rsp_data !== 64'd50 || rsp_hit !== 1'b1 || req_ready !== '0) begin
        bad++;
        $display("FAIL bp_hold%0d got v=%b data=%0d hit=%b rdy=%b want v=001 data=50 hit=1 rdy=000",
                 i, rsp_valid, rsp_data, rsp_hit, req_ready);
      end
      tick();
      #1;
    end
    rsp_ready[1] = 1'b0;
    release_rsp(0);
    w = model_winner(oh(2), exp_ptr);
    exp_ptr = (w + 1) % N;
    #1;
    total++;
    if (req_ready !== oh(w)) begin bad++; $display("FAIL bp_next_grant got=%b want=%b", req_ready, oh(w)); end
    wait_grant(g, tmo);
    wait_rsp(w, lat, n_rd, n_wr, n_both, tmo);
    total++;
    if (tmo || lat != 3 || rsp_data !== 64'd50 || rsp_valid !== oh(2)) begin
      bad++;
      $display("FAIL bp_second got lat=%0d data=%0d v=%b want 3/50/100", lat, rsp_data, rsp_valid);
    end
    release_rsp(w);
  endtask

  task automatic test_miss();
`ifdef AI_CACHE_ARB_STATS_EN
    logic [31:0] a0, h0, m0;
    a0 = stat_accesses; h0 = stat_hits; m0 = stat_misses;
`endif
    single_txn("miss30", 1, 1'b0, 32'd30, 64'd0);
    total++;
    if (rsp_hit !== 1'b0) begin bad++; $display("FAIL miss30_hit got=%b want=0", rsp_hit); end
`ifdef AI_CACHE_ARB_STATS_EN
    total++;
    if (stat_accesses !== a0 + 32'd1 || stat_hits !== h0 || stat_misses !== m0 + 32'd1) begin
      bad++;
      $display("FAIL stats_miss got a=%0d h=%0d m=%0d want a=%0d h=%0d m=%0d",
               stat_accesses, stat_hits, stat_misses, a0 + 1, h0, m0 + 1);
    end
    a0 = stat_accesses; h0 = stat_hits; m0 = stat_misses;
`endif
    single_txn("wr1000", 0, 1'b1, 32'd1000, 64'h1234_5678_9abc_def0);
`ifdef AI_CACHE_ARB_STATS_EN
    total++;
    if (stat_accesses !== a0 || stat_hits !== h0 || stat_misses !== m0) begin
      bad++;
      $display("FAIL stats_write got a=%0d h=%0d m=%0d want a=%0d h=%0d m=%0d",
               stat_accesses, stat_hits, stat_misses, a0, h0, m0);
    end
`endif
  endtask

  task automatic test_wrap();
    logic [N-1:0] g;
    bit tmo;
    int lat, n_rd, n_wr, n_both, w;
    single_txn("wrap_pre", 1, 1'b0, 32'd1000, 64'd0);
    set_req(0, 1'b0, 32'd5, 64'd0);
    set_req(2, 1'b0, 32'd1000, 64'd0);
    for (int t = 0; t < 2; t++) begin
      w = model_winner(req_valid, exp_ptr);
      exp_ptr = (w + 1) % N;
      wait_grant(g, tmo);
      total++;
      if (tmo || g !== oh(w)) begin bad++; $display("FAIL wrap_grant%0d got=%b want=%b", t, g, oh(w)); end
      wait_rsp(w, lat, n_rd, n_wr, n_both, tmo);
      total++;
      if (tmo || rsp_hit !== 1'b1 || rsp_data !== (w == 0 ? 64'd50 : 64'h1234_5678_9abc_def0)) begin
        bad++;
        $display("FAIL wrap_data%0d got hit=%b data=%h", t, rsp_hit, rsp_data);
      end
      release_rsp(w);
    end
  endtask

  task automatic test_reset_mid_resp();
    logic [N-1:0] g;
    bit tmo;
    int lat, n_rd, n_wr, n_both, w;
    set_req(1, 1'b0, 32'd5, 64'd0);
    w = model_winner(oh(1), exp_ptr);
    exp_ptr = (w + 1) % N;
    wait_grant(g, tmo);
    wait_rsp(1, lat, n_rd, n_wr, n_both, tmo);
    total++;
    if (tmo || rsp_valid !== oh(1)) begin bad++; $display("FAIL mid_pre got v=%b want=%b", rsp_valid, oh(1)); end
    set_req(1, 1'b0, 32'd5, 64'd0);
    set_req(2, 1'b0, 32'd30, 64'd0);
    reset = 1'b0;
    #1;
    total++;
    if ({req_ready, rsp_valid, cache_read_en, cache_write_en, rsp_hit, rsp_we, busy} !== '0 ||
        {cache_addr, cache_wdata, rsp_data} !== '0) begin
      bad++;
      $display("FAIL mid_reset_out got ctrl=%b rdata=%h want 0", {req_ready, rsp_valid, busy}, rsp_data);
    end
    tick();
    reset = 1'b1;
    exp_ptr = 0;
    #1;
    total++;
    if (rsp_valid !== '0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_dropped got v=%b busy=%b want 0/0", rsp_valid, busy);
    end
    w = model_winner(3'b110, exp_ptr);
    exp_ptr = (w + 1) % N;
    wait_grant(g, tmo);
    req_valid = '0;
    total++;
    if (tmo || g !== oh(w)) begin bad++; $display("FAIL mid_first_grant got=%b want=%b", g, oh(w)); end
    wait_rsp(w, lat, n_rd, n_wr, n_both, tmo);
    total++;
    if (tmo || lat != 3 || rsp_data !== 64'd50) begin
      bad++;
      $display("FAIL mid_first_rsp got lat=%0d data=%0d want 3/50", lat, rsp_data);
    end
    release_rsp(w);
  endtask

  task automatic test_random();
    logic [N-1:0] g, mask;
    bit tmo, eh;
    int lat, n_rd, n_wr, n_both, w;
    logic          pw [N];
    logic [AW-1:0] pa [N];
    logic [DW-1:0] pd [N];
    for (int t = 0; t < 30; t++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int r = 0; r < N; r++) begin
        pw[r] = 1'($urandom);
        pa[r] = 32'(100 + $urandom_range(0, 7));
        pd[r] = {$urandom, $urandom};
        if (mask[r]) set_req(r, pw[r], pa[r], pd[r]);
      end
      w = model_winner(mask, exp_ptr);
      exp_ptr = (w + 1) % N;
      wait_grant(g, tmo);
      total++;
      if (tmo || g !== oh(w)) begin bad++; $display("FAIL rnd%0d_grant got=%b want=%b", t, g, oh(w)); end
      wait_rsp(w, lat, n_rd, n_wr, n_both, tmo);
      total++;
      if (tmo || lat != 3 || n_both != 0 || n_rd != (pw[w] ? 0 : 1) || n_wr != (pw[w] ? 1 : 0)) begin
        bad++;
        $display("FAIL rnd%0d_timing got lat=%0d rd=%0d wr=%0d", t, lat, n_rd, n_wr);
      end
      eh = pw[w] ? 1'b0 : ref_mem.exists(pa[w]);
      total++;
      if (rsp_we !== pw[w] || rsp_valid !== oh(w) ||
          (pw[w] && rsp_data !== '0) ||
          (!pw[w] && (rsp_hit !== eh || (eh && rsp_data !== ref_mem[pa[w]])))) begin
        bad++;
        $display("FAIL rnd%0d_rsp got we=%b v=%b hit=%b data=%h want we=%b hit=%b", t, rsp_we, rsp_valid,
                 rsp_hit, rsp_data, pw[w], eh);
      end
      if (pw[w]) ref_mem[pa[w]] = pd[w];
      req_valid = '0;
      release_rsp(w);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) cval[i] = 1'b0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_backpressure();
    test_miss();
    test_wrap();
    test_reset_mid_resp();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
